dphy_lane_sequencer: RTL

Upstream lane sequencer for the DSI DAC output path. It accepts a packet of bytes over a valid/ready handshake and emits one 2-bit line state plus one 2-bit symbol per clock. The emitted sequence is LP stop, HS entry, optional sync byte, HS payload symbols, HS trail, then back to LP stop. Its outputs drive the `State`/`RGB_in` inputs of the P-type and N-type DAC slave instances; those instances convert each state/symbol pair to a DAC code.

---
 rtl/dphy_lane_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/dphy_lane_sequencer.sv
// D-PHY upstream lane sequencer: LP stop -> HS entry -> [sync 0xB8] -> payload -> trail.
// Optional sync byte enabled with `define DPHY_SYNC_EN.
module dphy_lane_sequencer #(
  parameter int T_LPX   = 4,
  parameter int T_PREP  = 4,
  parameter int T_ZERO  = 8,
  parameter int T_TRAIL = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [1:0] State,
  output logic [1:0] RGB_out,
  output logic       busy,
  output logic       underrun
);

  typedef enum logic [2:0] {
    ST_STOP, ST_RQST, ST_PREP, ST_ZERO, ST_SYNC, ST_DATA, ST_TRAIL
  } state_t;

`ifdef DPHY_SYNC_EN
  localparam logic [7:0] SYNC_BYTE = 8'hB8;
`endif

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] sreg_q, sreg_d;
  logic [1:0] idx_q, idx_d;
  logic       last_q, last_d;
  logic       in_ready_q, in_ready_d;
  logic [1:0] st_q, st_d;
  logic [1:0] sym_q, sym_d;
  logic       busy_q, busy_d;
  logic       und_q, und_d;
  logic       accept;

  assign accept   = in_valid & in_ready_q;
  assign in_ready = in_ready_q;
  assign State    = st_q;
  assign RGB_out  = sym_q;
  assign busy     = busy_q;
  assign underrun = und_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    idx_d   = idx_q;
    last_d  = last_q;
    und_d   = 1'b0;
    case (state_q)
      ST_STOP: if (in_valid) begin
        state_d = ST_RQST;
        cnt_d   = 8'(T_LPX - 1);
      end
      ST_RQST: if (cnt_q == 8'd0) begin
        state_d = ST_PREP;
        cnt_d   = 8'(T_PREP - 1);
      end else cnt_d = cnt_q - 8'd1;
      ST_PREP: if (cnt_q == 8'd0) begin
        state_d = ST_ZERO;
        cnt_d   = 8'(T_ZERO - 1);
      end else cnt_d = cnt_q - 8'd1;
      ST_ZERO: if (cnt_q == 8'd0) begin
`ifdef DPHY_SYNC_EN
        state_d = ST_SYNC;
        sreg_d  = SYNC_BYTE;
        idx_d   = 2'd0;
        last_d  = 1'b0;
`else
        // First byte is fetched on the final HS_ZERO cycle when there is no sync byte.
        if (accept) begin
          state_d = ST_DATA;
          sreg_d  = in_data;
          idx_d   = 2'd0;
          last_d  = in_last;
        end else begin
          state_d = ST_TRAIL;
          cnt_d   = 8'(T_TRAIL - 1);
          und_d   = 1'b1;
        end
`endif
      end else cnt_d = cnt_q - 8'd1;
`ifdef DPHY_SYNC_EN
      ST_SYNC,
`endif
      ST_DATA: begin
        if (idx_q != 2'd3) begin
          idx_d  = idx_q + 2'd1;
          sreg_d = {2'b00, sreg_q[7:2]};
        end else if (last_q) begin
          state_d = ST_TRAIL;
          cnt_d   = 8'(T_TRAIL - 1);
        end else if (accept) begin
          state_d = ST_DATA;
          sreg_d  = in_data;
          idx_d   = 2'd0;
          last_d  = in_last;
        end else begin
          state_d = ST_TRAIL;
          cnt_d   = 8'(T_TRAIL - 1);
          und_d   = 1'b1;
        end
      end
      ST_TRAIL: if (cnt_q == 8'd0) state_d = ST_STOP;
                else cnt_d = cnt_q - 8'd1;
      default: state_d = ST_STOP;
    endcase
  end

  // Outputs are derived from the next state so they register together with it.
  always_comb begin
    st_d  = 2'b10;
    sym_d = 2'b11;
    case (state_d)
      ST_STOP:  begin st_d = 2'b10; sym_d = 2'b11;       end
      ST_RQST:  begin st_d = 2'b10; sym_d = 2'b10;       end
      ST_PREP:  begin st_d = 2'b10; sym_d = 2'b01;       end
      ST_ZERO:  begin st_d = 2'b01; sym_d = 2'b00;       end
      ST_SYNC,
      ST_DATA:  begin st_d = 2'b00; sym_d = sreg_d[1:0]; end
      ST_TRAIL: begin st_d = 2'b11; sym_d = 2'b00;       end
      default:  begin st_d = 2'b10; sym_d = 2'b11;       end
    endcase
    busy_d     = (state_d != ST_STOP);
    in_ready_d = ((state_d == ST_SYNC) || (state_d == ST_DATA)) && (idx_d == 2'd3) && !last_d;
`ifndef DPHY_SYNC_EN
    in_ready_d = in_ready_d || ((state_d == ST_ZERO) && (cnt_d == 8'd0));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_STOP;
      cnt_q      <= 8'd0;
      sreg_q     <= 8'd0;
      idx_q      <= 2'd0;
      last_q     <= 1'b0;
      in_ready_q <= 1'b0;
      st_q       <= 2'b10;
      sym_q      <= 2'b11;
      busy_q     <= 1'b0;
      und_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sreg_q     <= sreg_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      in_ready_q <= in_ready_d;
      st_q       <= st_d;
      sym_q      <= sym_d;
      busy_q     <= busy_d;
      und_q      <= und_d;
    end
  end

endmodule
